// File: rtl/cmd_packer_pkg.sv
// Shared definitions for the compressed 5-word layer command.
// The command sequencer's decoder imports the same field positions.
package cmd_packer_pkg;

   localparam int CMD_BURST_LEN = 5;
   localparam int CMD_WORD_W    = 32;

   localparam logic [2:0] OP_IDLE     = 3'd0;
   localparam logic [2:0] OP_CONV3    = 3'd1;
   localparam logic [2:0] OP_CONV3P_1 = 3'd2;
   localparam logic [2:0] OP_POOL3    = 3'd3;
   localparam logic [2:0] OP_POOL13   = 3'd4;

   // Word 0: {stride_2, stride_1, 5'b0, op_type}
   localparam int W0_OP_LSB      = 0;
   localparam int W0_OP_W        = 3;
   localparam int W0_STRIDE1_LSB = 8;
   localparam int W0_STRIDE1_W   = 8;
   localparam int W0_STRIDE2_LSB = 16;
   localparam int W0_STRIDE2_W   = 16;

   // Word 1: {och_size, ich_size}
   localparam int W1_ICH_LSB = 0;
   localparam int W1_ICH_W   = 16;
   localparam int W1_OCH_LSB = 16;
   localparam int W1_OCH_W   = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } pk_state_e;

   function automatic logic [CMD_WORD_W-1:0] pack_w0(
      input logic [W0_OP_W-1:0]      op,
      input logic [W0_STRIDE1_W-1:0] s1,
      input logic [W0_STRIDE2_W-1:0] s2
   );
      logic [CMD_WORD_W-1:0] w;
      w = '0;
      w[W0_OP_LSB      +: W0_OP_W]      = op;
      w[W0_STRIDE1_LSB +: W0_STRIDE1_W] = s1;
      w[W0_STRIDE2_LSB +: W0_STRIDE2_W] = s2;
      return w;
   endfunction

   function automatic logic [CMD_WORD_W-1:0] pack_w1(
      input logic [W1_ICH_W-1:0] ich,
      input logic [W1_OCH_W-1:0] och
   );
      logic [CMD_WORD_W-1:0] w;
      w = '0;
      w[W1_ICH_LSB +: W1_ICH_W] = ich;
      w[W1_OCH_LSB +: W1_OCH_W] = och;
      return w;
   endfunction

endpackage

// File: rtl/cmd_packer.sv
// Serialises one layer descriptor into five command words for the command FIFO,
// tracking the running command size and flagging illegal or overflowing descriptors.
module cmd_packer
   import cmd_packer_pkg::*;
#(
   parameter int CMD_SPACE_WORDS = 128,
   parameter int OP_MAX          = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        desc_valid,
   output logic        desc_ready,
   input  logic [2:0]  op_type,
   input  logic [7:0]  stride_1,
   input  logic [15:0] stride_2,
   input  logic [15:0] ich_size,
   input  logic [15:0] och_size,
   input  logic [31:0] weight_start_addr,
   input  logic [31:0] data_start_addr,
   input  logic [31:0] wb_addr,
   input  logic        cmd_fifo_full,
   output logic        cmd_fifo_wr_en,
   output logic [31:0] cmd_fifo_din,
   input  logic        clear,
   output logic [6:0]  cmd_size,
   output logic        busy,
   output logic        err_op,
   output logic        cmd_overflow
);

   localparam logic [2:0] LP_OP_MAX   = 3'(OP_MAX);
   localparam logic [7:0] LP_SPACE    = 8'(CMD_SPACE_WORDS);
   localparam logic [7:0] LP_BURST    = 8'(CMD_BURST_LEN);
   localparam logic [6:0] LP_BURST_7  = 7'(CMD_BURST_LEN);
   localparam logic [2:0] LP_LAST_IDX = 3'(CMD_BURST_LEN - 1);

   pk_state_e   r_state;
   pk_state_e   w_next_state;
   logic [2:0]  r_word_idx;
   logic [6:0]  r_cmd_size;
   logic        r_err_op;
   logic        r_cmd_overflow;

   logic [2:0]  r_op_type;
   logic [7:0]  r_stride_1;
   logic [15:0] r_stride_2;
   logic [15:0] r_ich_size;
   logic [15:0] r_och_size;
   logic [31:0] r_weight_addr;
   logic [31:0] r_data_addr;
   logic [31:0] r_wb_addr;

   logic        w_accept;
   logic        w_op_bad;
   logic [6:0]  w_size_base;
   logic [7:0]  w_size_sum;
   logic        w_no_room;
   logic        w_launch;
   logic        w_wr;
   logic        w_last;
   logic [31:0] w_word;

   assign w_accept    = desc_valid && (r_state == ST_IDLE);
   assign w_op_bad    = (op_type == OP_IDLE) || (op_type > LP_OP_MAX);
   // A clear arriving with the descriptor zeroes the size before the capacity check.
   assign w_size_base = clear ? 7'd0 : r_cmd_size;
   assign w_size_sum  = {1'b0, w_size_base} + LP_BURST;
   assign w_no_room   = (w_size_sum > LP_SPACE);
   assign w_launch    = w_accept && !w_op_bad && !w_no_room;
   assign w_wr        = (r_state == ST_EMIT) && !cmd_fifo_full;
   assign w_last      = w_wr && (r_word_idx == LP_LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state   = r_state;
      desc_ready     = 1'b0;
      busy           = 1'b0;
      cmd_fifo_wr_en = 1'b0;
      w_word         = '0;
      case (r_state)
         ST_IDLE: begin
            desc_ready = 1'b1;
            if (w_launch) begin
               w_next_state = ST_EMIT;
            end
         end
         ST_EMIT: begin
            busy           = 1'b1;
            cmd_fifo_wr_en = !cmd_fifo_full;
            case (r_word_idx)
               3'd0:    w_word = pack_w0(r_op_type, r_stride_1, r_stride_2);
               3'd1:    w_word = pack_w1(r_ich_size, r_och_size);
               3'd2:    w_word = r_weight_addr;
               3'd3:    w_word = r_data_addr;
               3'd4:    w_word = r_wb_addr;
               default: w_word = '0;
            endcase
            if (w_last) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_word_idx     <= '0;
         r_cmd_size     <= '0;
         r_err_op       <= 1'b0;
         r_cmd_overflow <= 1'b0;
         r_op_type      <= '0;
         r_stride_1     <= '0;
         r_stride_2     <= '0;
         r_ich_size     <= '0;
         r_och_size     <= '0;
         r_weight_addr  <= '0;
         r_data_addr    <= '0;
         r_wb_addr      <= '0;
      end else begin
         if (w_accept) begin
            r_op_type     <= op_type;
            r_stride_1    <= stride_1;
            r_stride_2    <= stride_2;
            r_ich_size    <= ich_size;
            r_och_size    <= och_size;
            r_weight_addr <= weight_start_addr;
            r_data_addr   <= data_start_addr;
            r_wb_addr     <= wb_addr;
         end

         // Clear is only meaningful between commands; during emission it is dropped.
         if (r_state == ST_IDLE) begin
            if (clear) begin
               r_cmd_size     <= '0;
               r_err_op       <= 1'b0;
               r_cmd_overflow <= 1'b0;
            end
            if (w_accept && w_op_bad) begin
               r_err_op <= 1'b1;
            end else if (w_accept && w_no_room) begin
               r_cmd_overflow <= 1'b1;
            end
         end

         if (w_launch || w_last) begin
            r_word_idx <= '0;
         end else if (w_wr) begin
            r_word_idx <= r_word_idx + 3'd1;
         end

         if (w_last) begin
            r_cmd_size <= r_cmd_size + LP_BURST_7;
         end
      end
   end

   assign cmd_fifo_din = w_word;
   assign cmd_size     = r_cmd_size;
   assign err_op       = r_err_op;
   assign cmd_overflow = r_cmd_overflow;

endmodule

// File: tb/tb_cmd_packer.sv
// Scenario bench for cmd_packer: expected command words are queued as descriptors
// are driven and compared against the words the FIFO interface actually received.
module tb_cmd_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        desc_valid = 1'b0;
   logic        desc_ready;
   logic [2:0]  op_type = '0;
   logic [7:0]  stride_1 = '0;
   logic [15:0] stride_2 = '0;
   logic [15:0] ich_size = '0;
   logic [15:0] och_size = '0;
   logic [31:0] weight_start_addr = '0;
   logic [31:0] data_start_addr = '0;
   logic [31:0] wb_addr = '0;
   logic        cmd_fifo_full = 1'b0;
   logic        cmd_fifo_wr_en;
   logic [31:0] cmd_fifo_din;
   logic        clear = 1'b0;
   logic [6:0]  cmd_size;
   logic        busy;
   logic        err_op;
   logic        cmd_overflow;

   int          n_pass = 0;
   int          n_total = 0;
   int          bad_wr = 0;
   int          m_size = 0;
   logic        m_err = 1'b0;
   logic        m_ovf = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] act_q[$];

   always #5 clk = ~clk;

   cmd_packer dut (
      .clk              (clk),
      .rst              (rst),
      .desc_valid       (desc_valid),
      .desc_ready       (desc_ready),
      .op_type          (op_type),
      .stride_1         (stride_1),
      .stride_2         (stride_2),
      .ich_size         (ich_size),
      .och_size         (och_size),
      .weight_start_addr(weight_start_addr),
      .data_start_addr  (data_start_addr),
      .wb_addr          (wb_addr),
      .cmd_fifo_full    (cmd_fifo_full),
      .cmd_fifo_wr_en   (cmd_fifo_wr_en),
      .cmd_fifo_din     (cmd_fifo_din),
      .clear            (clear),
      .cmd_size         (cmd_size),
      .busy             (busy),
      .err_op           (err_op),
      .cmd_overflow     (cmd_overflow)
   );

   // Advance to the next falling edge and capture any FIFO write seen there.
   task automatic tick();
      @(negedge clk);
      if (cmd_fifo_wr_en === 1'b1) begin
         act_q.push_back(cmd_fifo_din);
         if (cmd_fifo_full !== 1'b0 || busy !== 1'b1) bad_wr++;
      end
   endtask

   task automatic set_desc(input logic [7:0] s1, input logic [15:0] s2, input logic [15:0] ich,
                           input logic [15:0] och, input logic [31:0] wt, input logic [31:0] dt,
                           input logic [31:0] wb);
      stride_1 = s1; stride_2 = s2; ich_size = ich; och_size = och;
      weight_start_addr = wt; data_start_addr = dt; wb_addr = wb;
   endtask

   // Called at a falling edge while idle; returns at the falling edge of cycle N+1.
   task automatic send(input logic [2:0] op);
      if (clear) begin
         m_size = 0; m_err = 1'b0; m_ovf = 1'b0;
      end
      if (op == 3'd0 || op > 3'd4) begin
         m_err = 1'b1;
      end else if (m_size + 5 > 128) begin
         m_ovf = 1'b1;
      end else begin
         exp_q.push_back({stride_2, stride_1, 5'b00000, op});
         exp_q.push_back({och_size, ich_size});
         exp_q.push_back(weight_start_addr);
         exp_q.push_back(data_start_addr);
         exp_q.push_back(wb_addr);
         m_size += 5;
      end
      op_type = op;
      desc_valid = 1'b1;
      tick();
      desc_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int c;
      c = 0;
      while (desc_ready !== 1'b1 && c < 40) begin
         tick();
         c++;
      end
      if (desc_ready !== 1'b1) begin
         n_total++;
         $display("FAIL %s_timeout: desc_ready=%b after %0d cycles, required 1", tag, desc_ready, c);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      n_total++; if (desc_ready !== 1'b1) $display("FAIL rst_ready: got %b, required 1", desc_ready); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else n_pass++;
      n_total++; if (cmd_fifo_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b, required 0", cmd_fifo_wr_en); else n_pass++;
      n_total++; if (cmd_fifo_din !== 32'h0) $display("FAIL rst_din: got %08h, required 0", cmd_fifo_din); else n_pass++;
      n_total++; if (cmd_size !== 7'd0) $display("FAIL rst_size: got %0d, required 0", cmd_size); else n_pass++;
      n_total++; if (err_op !== 1'b0) $display("FAIL rst_err_op: got %b, required 0", err_op); else n_pass++;
      n_total++; if (cmd_overflow !== 1'b0) $display("FAIL rst_overflow: got %b, required 0", cmd_overflow); else n_pass++;
      rst = 1'b0;
      act_q.delete();
      tick();
   endtask

   task automatic test_basic();
      logic [31:0] a, e;
      set_desc(8'd13, 16'd169, 16'd64, 16'd128, 32'h0000_1000, 32'h0029_0000, 32'h002E_0000);
      send(3'd1);
      n_total++; if (cmd_fifo_wr_en !== 1'b1 || cmd_fifo_din !== 32'h00A9_0D01)
         $display("FAIL basic_w0_n1: wr_en=%b din=%08h, required 1/00a90d01", cmd_fifo_wr_en, cmd_fifo_din); else n_pass++;
      tick(); tick(); tick(); tick();
      n_total++; if (desc_ready !== 1'b0 || cmd_fifo_din !== 32'h002E_0000)
         $display("FAIL basic_n5: ready=%b din=%08h, required 0/002e0000", desc_ready, cmd_fifo_din); else n_pass++;
      tick();
      n_total++; if (desc_ready !== 1'b1) $display("FAIL basic_ready_n6: got %b, required 1", desc_ready); else n_pass++;
      n_total++; if (cmd_size !== 7'd5) $display("FAIL basic_size: got %0d, required 5", cmd_size); else n_pass++;
      n_total++;
      if (act_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d words, required %0d", act_q.size(), exp_q.size());
      else n_pass++;
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         a = act_q.pop_front(); e = exp_q.pop_front(); n_total++;
         if (a !== e) $display("FAIL basic_word: got %08h, required %08h", a, e); else n_pass++;
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_backpressure();
      logic [31:0] a, e;
      set_desc(8'd13, 16'd169, 16'd64, 16'd128, 32'h0000_1000, 32'h0029_0000, 32'h002E_0000);
      send(3'd1);
      @(posedge clk); #1 cmd_fifo_full = 1'b1;
      for (int c = 2; c <= 4; c++) begin
         tick();
         n_total++; if (cmd_fifo_wr_en !== 1'b0 || cmd_fifo_din !== 32'h0080_0040)
            $display("FAIL bp_hold_n%0d: wr_en=%b din=%08h, required 0/00800040", c, cmd_fifo_wr_en, cmd_fifo_din);
         else n_pass++;
      end
      @(posedge clk); #1 cmd_fifo_full = 1'b0;
      tick(); tick(); tick(); tick();
      n_total++; if (desc_ready !== 1'b0) $display("FAIL bp_ready_n8: got %b, required 0", desc_ready); else n_pass++;
      tick();
      n_total++; if (desc_ready !== 1'b1) $display("FAIL bp_ready_n9: got %b, required 1", desc_ready); else n_pass++;
      n_total++; if (cmd_size !== 7'(m_size)) $display("FAIL bp_size: got %0d, required %0d", cmd_size, m_size); else n_pass++;
      n_total++;
      if (act_q.size() != exp_q.size()) $display("FAIL bp_count: got %0d words, required %0d", act_q.size(), exp_q.size());
      else n_pass++;
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         a = act_q.pop_front(); e = exp_q.pop_front(); n_total++;
         if (a !== e) $display("FAIL bp_word: got %08h, required %08h", a, e); else n_pass++;
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_illegal_op();
      logic [2:0] bad_ops [2];
      bad_ops[0] = 3'd0;
      bad_ops[1] = 3'd5;
      for (int i = 0; i < 2; i++) begin
         set_desc(8'd1, 16'd2, 16'd3, 16'd4, 32'h5, 32'h6, 32'h7);
         send(bad_ops[i]);
         n_total++; if (cmd_fifo_wr_en !== 1'b0 || desc_ready !== 1'b1)
            $display("FAIL illegal_%0d_idle: wr_en=%b ready=%b, required 0/1", bad_ops[i], cmd_fifo_wr_en, desc_ready); else n_pass++;
         n_total++; if (err_op !== m_err) $display("FAIL illegal_%0d_err: got %b, required %b", bad_ops[i], err_op, m_err); else n_pass++;
         n_total++; if (cmd_size !== 7'(m_size)) $display("FAIL illegal_%0d_size: got %0d, required %0d", bad_ops[i], cmd_size, m_size); else n_pass++;
         clear = 1'b1; m_size = 0; m_err = 1'b0; m_ovf = 1'b0;
         tick();
         clear = 1'b0;
         tick();
         n_total++; if (err_op !== 1'b0 || cmd_size !== 7'd0)
            $display("FAIL illegal_clear: err_op=%b size=%0d, required 0/0", err_op, cmd_size); else n_pass++;
      end
      n_total++;
      if (act_q.size() != 0 || exp_q.size() != 0) $display("FAIL illegal_writes: got %0d words, required 0", act_q.size());
      else n_pass++;
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_overflow_clear();
      logic [31:0] a, e;
      for (int i = 0; i < 25; i++) begin
         set_desc(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $urandom, $urandom, $urandom);
         send(3'($urandom_range(1, 4)));
         wait_idle("ovf_fill");
      end
      n_total++; if (cmd_size !== 7'd125 || cmd_overflow !== 1'b0)
         $display("FAIL ovf_full: size=%0d ovf=%b, required 125/0", cmd_size, cmd_overflow); else n_pass++;
      send(3'd2);
      n_total++; if (cmd_fifo_wr_en !== 1'b0 || desc_ready !== 1'b1)
         $display("FAIL ovf_drop: wr_en=%b ready=%b, required 0/1", cmd_fifo_wr_en, desc_ready); else n_pass++;
      n_total++; if (cmd_overflow !== 1'b1 || cmd_size !== 7'd125)
         $display("FAIL ovf_flag: ovf=%b size=%0d, required 1/125", cmd_overflow, cmd_size); else n_pass++;
      set_desc(8'h5A, 16'hA55A, 16'h0010, 16'h0020, 32'hDEAD_0000, 32'hBEEF_0000, 32'hCAFE_0000);
      clear = 1'b1;
      send(3'd3);
      clear = 1'b0;
      n_total++; if (cmd_fifo_wr_en !== 1'b1 || cmd_overflow !== 1'b0)
         $display("FAIL ovf_clear_accept: wr_en=%b ovf=%b, required 1/0", cmd_fifo_wr_en, cmd_overflow); else n_pass++;
      wait_idle("ovf_clear");
      n_total++; if (cmd_size !== 7'd5) $display("FAIL ovf_clear_size: got %0d, required 5", cmd_size); else n_pass++;
      clear = 1'b1; m_size = 0; m_err = 1'b0; m_ovf = 1'b0;
      tick();
      clear = 1'b0;
      tick();
      n_total++; if (cmd_size !== 7'd0 || cmd_overflow !== 1'b0)
         $display("FAIL ovf_idle_clear: size=%0d ovf=%b, required 0/0", cmd_size, cmd_overflow); else n_pass++;
      n_total++;
      if (act_q.size() != exp_q.size()) $display("FAIL ovf_count: got %0d words, required %0d", act_q.size(), exp_q.size());
      else n_pass++;
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         a = act_q.pop_front(); e = exp_q.pop_front(); n_total++;
         if (a !== e) $display("FAIL ovf_word: got %08h, required %08h", a, e); else n_pass++;
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [31:0] a, e;
      set_desc(8'd7, 16'd49, 16'd3, 16'd16, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666);
      send(3'd2);
      tick();
      rst = 1'b1;
      tick();
      void'(exp_q.pop_back()); void'(exp_q.pop_back()); void'(exp_q.pop_back());
      m_size = 0; m_err = 1'b0; m_ovf = 1'b0;
      n_total++; if (cmd_fifo_wr_en !== 1'b0 || busy !== 1'b0)
         $display("FAIL rmid_stop: wr_en=%b busy=%b, required 0/0", cmd_fifo_wr_en, busy); else n_pass++;
      n_total++; if (desc_ready !== 1'b1 || cmd_size !== 7'd0)
         $display("FAIL rmid_state: ready=%b size=%0d, required 1/0", desc_ready, cmd_size); else n_pass++;
      rst = 1'b0;
      tick();
      set_desc(8'd9, 16'd81, 16'd32, 16'd32, 32'hAAAA_0000, 32'hBBBB_0000, 32'hCCCC_0000);
      send(3'd4);
      n_total++; if (cmd_fifo_wr_en !== 1'b1 || cmd_fifo_din !== 32'h0051_0904)
         $display("FAIL rmid_restart_w0: wr_en=%b din=%08h, required 1/00510904", cmd_fifo_wr_en, cmd_fifo_din); else n_pass++;
      wait_idle("rmid");
      n_total++; if (cmd_size !== 7'd5) $display("FAIL rmid_size: got %0d, required 5", cmd_size); else n_pass++;
      n_total++;
      if (act_q.size() != exp_q.size()) $display("FAIL rmid_count: got %0d words, required %0d", act_q.size(), exp_q.size());
      else n_pass++;
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         a = act_q.pop_front(); e = exp_q.pop_front(); n_total++;
         if (a !== e) $display("FAIL rmid_word: got %08h, required %08h", a, e); else n_pass++;
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_clear_in_emit();
      logic [31:0] a, e;
      clear = 1'b1; m_size = 0; m_err = 1'b0; m_ovf = 1'b0;
      tick();
      clear = 1'b0;
      set_desc(8'd2, 16'd4, 16'd6, 16'd8, 32'h10, 32'h20, 32'h30);
      send(3'd7);
      n_total++; if (err_op !== 1'b1 || cmd_size !== 7'd0)
         $display("FAIL cemit_pre: err_op=%b size=%0d, required 1/0", err_op, cmd_size); else n_pass++;
      set_desc(8'd26, 16'd676, 16'd256, 16'd512, 32'h0100_0000, 32'h0200_0000, 32'h0300_0000);
      send(3'd3);
      tick();
      @(posedge clk); #1 clear = 1'b1;
      tick();
      @(posedge clk); #1 clear = 1'b0;
      wait_idle("cemit");
      n_total++; if (cmd_size !== 7'(m_size)) $display("FAIL cemit_size: got %0d, required %0d", cmd_size, m_size); else n_pass++;
      n_total++; if (err_op !== 1'b1) $display("FAIL cemit_err_kept: got %b, required 1", err_op); else n_pass++;
      n_total++;
      if (act_q.size() != exp_q.size()) $display("FAIL cemit_count: got %0d words, required %0d", act_q.size(), exp_q.size());
      else n_pass++;
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         a = act_q.pop_front(); e = exp_q.pop_front(); n_total++;
         if (a !== e) $display("FAIL cemit_word: got %08h, required %08h", a, e); else n_pass++;
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_write_protocol();
      n_total++;
      if (bad_wr !== 0) $display("FAIL wr_protocol: %0d writes while full or idle, required 0", bad_wr);
      else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_illegal_op();
      test_overflow_clear();
      test_reset_mid();
      test_clear_in_emit();
      test_write_protocol();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
